// File: rtl/quadrature_emulator.sv
// Free-running quadrature square-wave source emulating an incremental encoder.
// phs_0 is divided down from clk; phs_90 follows it DIV half-clk periods later.
module quadrature_emulator #(
  parameter int unsigned DIV     = 1,
  parameter bit          REVERSE = 1'b0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic clk,
  input  logic nrst,
  output logic phs_0,
  output logic phs_90
);

  localparam logic [CNT_W-1:0] CntLast    = CNT_W'(DIV - 1);
  // Counter value that sits DIV half-cycles after a phs_0 toggle: on a rising
  // edge for even DIV, on the falling edge inside that count for odd DIV.
  localparam logic [CNT_W-1:0] CntQuarter = CNT_W'((DIV - 1) / 2);

  logic [CNT_W-1:0] cnt_q;
  logic             started_q;
  logic             quarter_hit;
  logic             phs_90_next;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q     <= '0;
      phs_0     <= 1'b0;
      started_q <= 1'b0;
    end else if (cnt_q == CntLast) begin
      cnt_q     <= '0;
      phs_0     <= ~phs_0;
      started_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // started_q gates the follower so counter passes before the first toggle
  // are ignored; clearing it also flushes phs_90 after a single-edge reset.
  assign quarter_hit = started_q && (cnt_q == CntQuarter);
  assign phs_90_next = phs_0 ^ REVERSE;

  generate
    if (DIV % 2 == 1) begin : g_fall
      always_ff @(negedge clk) begin
        if (!nrst || !started_q) begin
          phs_90 <= 1'b0;
        end else if (quarter_hit) begin
          phs_90 <= phs_90_next;
        end
      end
    end else begin : g_rise
      always_ff @(posedge clk) begin
        if (!nrst || !started_q) begin
          phs_90 <= 1'b0;
        end else if (quarter_hit) begin
          phs_90 <= phs_90_next;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_quadrature_emulator.sv
// Bench for quadrature_emulator: four parameterisations checked every edge
// against an arithmetic half-cycle model, plus directed literal checks.
module tb_quadrature_emulator;

  localparam int NDUT = 4;
  localparam int DIVS [NDUT] = '{1, 4, 3, 5};
  localparam int REVS [NDUT] = '{0, 0, 1, 0};

  logic clk;
  logic nrst;
  logic p0  [NDUT];
  logic p90 [NDUT];

  int checks;
  int errors;
  bit checking;
  bit duty_en;
  int s;
  bit prev90 [NDUT];
  logic last0 [NDUT];
  logic last90 [NDUT];
  int hi0 [NDUT];
  int hi90 [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    quadrature_emulator #(
      .DIV    (DIVS[g]),
      .REVERSE(REVS[g] != 0),
      .CNT_W  (16)
    ) u_dut (
      .clk   (clk),
      .nrst  (nrst),
      .phs_0 (p0[g]),
      .phs_90(p90[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // s counts half-clk periods: 0/1 while in reset, first released rising edge is 2.
  function automatic bit m0(input int hs, input int d);
    return ((hs / 2) / d) % 2 != 0;
  endfunction

  function automatic bit m90(input int hs, input int d, input int r);
    if (hs < 3 * d) return 1'b0;
    return ((((hs - d) / (2 * d)) % 2) != 0) ^ (r != 0);
  endfunction

  always @(clk) begin
    bit rise;
    bit nr;
    rise = (clk === 1'b1);
    nr   = (nrst === 1'b1);
    if (!nr) s = rise ? 0 : 1;
    else     s = s + 1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      bit e0;
      bit e90;
      e0  = m0(s, DIVS[k]);
      e90 = m90(s, DIVS[k], REVS[k]);
      // Odd-DIV phs_90 lives on the falling edge and clears one half-cycle late.
      if (!nr && rise && (DIVS[k] % 2 == 1)) e90 = prev90[k];
      prev90[k] = e90;
      if (checking) begin
        chk($sformatf("u%0d_phs_0", k), p0[k], e0);
        chk($sformatf("u%0d_phs_90", k), p90[k], e90);
        if (nr) chk($sformatf("u%0d_gray", k), (p0[k] !== last0[k]) && (p90[k] !== last90[k]),
                    1'b0);
      end
      if (duty_en) begin
        if (p0[k] === 1'b1) hi0[k]++;
        if (p90[k] === 1'b1) hi90[k]++;
      end
      last0[k]  = p0[k];
      last90[k] = p90[k];
    end
  end

  initial begin
    bit found;
    checks   = 0;
    errors   = 0;
    checking = 1'b0;
    duty_en  = 1'b0;
    s        = 0;
    for (int k = 0; k < NDUT; k++) begin
      prev90[k] = 1'b0;
      hi0[k]    = 0;
      hi90[k]   = 0;
    end
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 checking = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("reset_u%0d_phs_0", k), p0[k], 1'b0);
      chk($sformatf("reset_u%0d_phs_90", k), p90[k], 1'b0);
    end
    #1 nrst = 1'b1;

    // First released rising edge: DIV=1 gives 10, then 11 on the falling edge.
    @(posedge clk); #1;
    chk("rel_div1_phs_0", p0[0], 1'b1);
    chk("rel_div1_phs_90", p90[0], 1'b0);
    chk("rel_div4_phs_0", p0[1], 1'b0);
    @(negedge clk); #1;
    chk("rel_div1_fall_phs_90", p90[0], 1'b1);
    for (int n = 2; n <= 7; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin
        chk("div1_n2_phs_0", p0[0], 1'b0);
        chk("div1_n2_phs_90", p90[0], 1'b1);
      end
      if (n == 3) begin
        chk("div3r_n3_phs_0", p0[2], 1'b1);
        chk("div3r_n3_phs_90", p90[2], 1'b0);
      end
      if (n == 5) begin
        chk("div4_n5_phs_0", p0[1], 1'b1);
        chk("div4_n5_phs_90", p90[1], 1'b0);
      end
      if (n == 6) chk("div4_n6_phs_90", p90[1], 1'b1);
    end
    @(negedge clk); #1;
    chk("div3r_lead_phs_0", p0[2], 1'b0);
    chk("div3r_lead_phs_90", p90[2], 1'b1);
    repeat (20) @(posedge clk);

    // Single-rising-edge reset pulse while DIV=1 outputs read 11.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(clk); #1;
      if (p0[0] === 1'b1 && p90[0] === 1'b1) found = 1'b1;
    end
    chk("find_11", found, 1'b1);
    #1 nrst = 1'b0;
    @(posedge clk); #1;
    chk("mid_div1_phs_0", p0[0], 1'b0);
    chk("mid_div4_phs_0", p0[1], 1'b0);
    chk("mid_div4_phs_90", p90[1], 1'b0);
    #1 nrst = 1'b1;
    @(negedge clk); #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("mid_u%0d_phs_0", k), p0[k], 1'b0);
      chk($sformatf("mid_u%0d_phs_90", k), p90[k], 1'b0);
    end
    @(posedge clk); #1;
    chk("restart_div1_phs_0", p0[0], 1'b1);
    chk("restart_div1_phs_90", p90[0], 1'b0);
    @(negedge clk); #1;
    chk("restart_div1_fall_phs_90", p90[0], 1'b1);

    // Duty window of 2000 half-cycles: a whole number of periods for DIV=1 and DIV=5.
    repeat (40) @(posedge clk);
    #2 duty_en = 1'b1;
    repeat (1000) @(posedge clk);
    #2 duty_en = 1'b0;
    checks++;
    if (hi0[0] != 1000) begin
      errors++;
      $display("FAIL duty_div1_phs_0: got %0d expected 1000", hi0[0]);
    end
    checks++;
    if (hi90[0] != 1000) begin
      errors++;
      $display("FAIL duty_div1_phs_90: got %0d expected 1000", hi90[0]);
    end
    checks++;
    if (hi0[3] != 1000) begin
      errors++;
      $display("FAIL duty_div5_phs_0: got %0d expected 1000", hi0[3]);
    end
    checks++;
    if (hi90[3] != 1000) begin
      errors++;
      $display("FAIL duty_div5_phs_90: got %0d expected 1000", hi90[3]);
    end

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
